imem_loader: RTL and testbench

- Boot-time front end that sits directly upstream of the processor core.
- Receives a program image over a UART RX line (8N1, LSB first) and writes it word by word into the core's 32-bit instruction memory write port.
- Holds the core in reset through `proc_rst` until the whole image is written, then releases it.
- Any protocol or line error parks the block in an error state, with the core still held in reset.

---
 rtl/imem_loader.sv | 271 +++++++++++++++++++++++++++
 tb/tb_imem_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time front end for the processor core. A program image arrives over a
// UART RX line (8N1, LSB first). It is assembled into little-endian 32-bit
// words and written into the core's instruction memory one word at a time.
// The core is held in reset until the whole image has been written. A line or
// protocol error parks the block in an error state, and the core stays in
// reset until `rst` is asserted.
//
// Image format: the first word is the word count N. It is followed by N data
// words, which are written to addresses 0 .. N-1.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   rxd       UART receive line, idle high, asynchronous to clk
//   mem_addr  imem word address for the write (ADDR_WIDTH bits)
//   mem_data  imem write data (32 bits)
//   mem_we    imem write strobe, single-cycle pulse
//   proc_rst  reset to the processor core, active high
//   err       sticky error flag
//   done      image fully loaded
//
// Parameters:
//   CLK_PER_BIT  clock cycles per UART bit (must be >= 4)
//   ADDR_WIDTH   instruction memory word-address width
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int CLK_PER_BIT = 868,
    parameter int ADDR_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_data,
    output logic                  mem_we,
    output logic                  proc_rst,
    output logic                  err,
    output logic                  done
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);

    // Last count value of a full bit period and of half a bit period.
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);

    // Largest image the memory can hold, in words.
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

    // The word index has one extra bit, so N = 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] IDX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // Stage p0/p1: two-flop synchronizer for the asynchronous RX line.
    // Stage p2: delayed copy of the synchronized line, used for edge detection.
    // -------------------------------------------------------------------------
    logic rxd_p0;
    logic rxd_p1;
    logic rxd_p2;
    logic rx_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
            rxd_p2 <= 1'b1;
        end else begin
            rxd_p0 <= rxd;
            rxd_p1 <= rxd_p0;
            rxd_p2 <= rxd_p1;
        end
    end

    assign rx_fall = rxd_p2 & ~rxd_p1;

    // -------------------------------------------------------------------------
    // UART byte receiver
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t        rx_state;
    logic [CNT_W-1:0] bit_tmr;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             byte_valid;
    logic             frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            bit_tmr    <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            case (rx_state)
                RX_IDLE: begin
                    bit_tmr <= '0;
                    bit_idx <= '0;
                    if (rx_fall) begin
                        rx_state <= RX_START;
                    end
                end

                // Re-check the line at the middle of the start bit. A line that
                // is already high again was a glitch, so drop it silently.
                RX_START: begin
                    if (bit_tmr == HALF_LAST) begin
                        bit_tmr  <= '0;
                        rx_state <= rxd_p1 ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_tmr <= bit_tmr + 1'b1;
                    end
                end

                // Sampling is now aligned to mid-bit. Shift right so that the
                // first bit received (the LSB) ends up in bit 0.
                RX_DATA: begin
                    if (bit_tmr == BIT_LAST) begin
                        bit_tmr  <= '0;
                        rx_shift <= {rxd_p1, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        bit_tmr <= bit_tmr + 1'b1;
                    end
                end

                RX_STOP: begin
                    if (bit_tmr == BIT_LAST) begin
                        bit_tmr  <= '0;
                        rx_state <= RX_IDLE;
                        if (rxd_p1) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        bit_tmr <= bit_tmr + 1'b1;
                    end
                end

                default: begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Little-endian word assembly. Only the first three bytes are stored. The
    // fourth byte is taken straight from the receiver, so the word event occurs
    // in the same cycle as that byte's byte_valid.
    // -------------------------------------------------------------------------
    logic [1:0]  byte_cnt;
    logic [23:0] word_acc;
    logic        word_evt;
    logic [31:0] word_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            word_acc <= '0;
        end else if (byte_valid) begin
            case (byte_cnt)
                2'd0:    word_acc[7:0]   <= rx_shift;
                2'd1:    word_acc[15:8]  <= rx_shift;
                2'd2:    word_acc[23:16] <= rx_shift;
                default: word_acc        <= word_acc;
            endcase
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

    assign word_evt = byte_valid && (byte_cnt == 2'd3);
    assign word_val = {rx_shift, word_acc};

    // -------------------------------------------------------------------------
    // Loader FSM with registered memory-port and status outputs
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        LD_LEN,
        LD_DATA,
        LD_DONE,
        LD_ERR
    } ld_state_t;

    ld_state_t       ld_state;
    logic [ADDR_WIDTH:0] n_words;
    logic [ADDR_WIDTH:0] wr_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_state <= LD_LEN;
            n_words  <= '0;
            wr_idx   <= '0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_we   <= 1'b0;
            proc_rst <= 1'b1;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            mem_we <= 1'b0;

            // The status outputs follow the state one cycle later. This keeps
            // the core in reset through the cycle of the final write.
            done     <= (ld_state == LD_DONE);
            proc_rst <= (ld_state != LD_DONE);
            err      <= (ld_state == LD_ERR);

            case (ld_state)
                LD_LEN: begin
                    if (frame_err) begin
                        ld_state <= LD_ERR;
                    end else if (word_evt) begin
                        if (word_val == '0) begin
                            ld_state <= LD_DONE;
                        end else if (word_val > MAX_WORDS) begin
                            ld_state <= LD_ERR;
                        end else begin
                            n_words  <= word_val[ADDR_WIDTH:0];
                            wr_idx   <= '0;
                            ld_state <= LD_DATA;
                        end
                    end
                end

                // The address is the low bits of the index. It wraps only after
                // the final write of a full-size image.
                LD_DATA: begin
                    if (frame_err) begin
                        ld_state <= LD_ERR;
                    end else if (word_evt) begin
                        mem_we   <= 1'b1;
                        mem_addr <= wr_idx[ADDR_WIDTH-1:0];
                        mem_data <= word_val;
                        wr_idx   <= wr_idx + IDX_ONE;
                        if (wr_idx == n_words - IDX_ONE) begin
                            ld_state <= LD_DONE;
                        end
                    end
                end

                // DONE and ERR are terminal: traffic is ignored until rst.
                LD_DONE: begin
                    ld_state <= LD_DONE;
                end

                default: begin
                    ld_state <= LD_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Bench for imem_loader with CLK_PER_BIT = 4 and ADDR_WIDTH = 12. A table of
// byte streams, each with its expected writes and final status, drives most of
// the checks. Hand-written sequences cover the glitch and mid-stream reset
// cases.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int CPB = 4;
    localparam int AW  = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rxd = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic          mem_we;
    logic          proc_rst;
    logic          err;
    logic          done;

    imem_loader #(
        .CLK_PER_BIT(CPB),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rxd     (rxd),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_we  (mem_we),
        .proc_rst(proc_rst),
        .err     (err),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Write / release monitor, sampled on the falling edge.
    logic [AW-1:0] wr_addr [0:63];
    logic [31:0]   wr_data [0:63];
    logic          wr_prst [0:63];
    int            wr_total  = 0;
    int            rel_total = 0;
    int            b2b_total = 0;
    logic          we_prev   = 1'b0;
    logic          prst_prev = 1'b0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_total < 64) begin
                wr_addr[wr_total] <= mem_addr;
                wr_data[wr_total] <= mem_data;
                wr_prst[wr_total] <= proc_rst;
            end
            wr_total <= wr_total + 1;
            if (we_prev) b2b_total <= b2b_total + 1;
        end
        we_prev <= (mem_we === 1'b1);
        if (prst_prev && (proc_rst === 1'b0)) rel_total <= rel_total + 1;
        prst_prev <= (proc_rst === 1'b1);
    end

    typedef struct {
        string            name;
        int               nbytes;
        logic [0:15][7:0] bytes;
        int               bad_idx;
        int               exp_wr;
        logic [31:0]      d0;
        logic [31:0]      d1;
        logic             exp_done;
        logic             exp_err;
    } vec_t;

    vec_t vecs [0:4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int k = 0; k < 8; k++) drive_bit(b[k]);
        drive_bit(stop_ok);
        drive_bit(1'b1);
    endtask

    // Assert rst between clock edges and check the outputs before any edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst proc_rst", proc_rst, 1);
        check("rst mem_we", mem_we, 0);
        check("rst err", err, 0);
        check("rst done", done, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_data", mem_data, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_result(input string nm, input int bw, input int br, input int bb,
                                input int exp_wr, input logic [31:0] d0, input logic [31:0] d1,
                                input logic exp_done, input logic exp_err);
        check({nm, " write count"}, wr_total - bw, exp_wr);
        for (int i = 0; i < exp_wr; i++) begin
            check({nm, " addr"}, wr_addr[bw + i], i);
            check({nm, " data"}, wr_data[bw + i], (i == 0) ? d0 : d1);
            check({nm, " proc_rst at write"}, wr_prst[bw + i], 1);
        end
        check({nm, " done"}, done, exp_done);
        check({nm, " proc_rst"}, proc_rst, !exp_done);
        check({nm, " err"}, err, exp_err);
        check({nm, " back-to-back we"}, b2b_total - bb, 0);
        check({nm, " releases"}, rel_total - br, exp_done);
    endtask

    task automatic run_vec(input vec_t vv);
        int bw, br, bb;
        do_reset();
        bw = wr_total;
        br = rel_total;
        bb = b2b_total;
        repeat (5) @(posedge clk);
        for (int i = 0; i < vv.nbytes; i++) send_byte(vv.bytes[i], i != vv.bad_idx);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_result(vv.name, bw, br, bb, vv.exp_wr, vv.d0, vv.d1, vv.exp_done, vv.exp_err);
    endtask

    task automatic send_normal(input int count);
        for (int i = 0; i < count; i++) send_byte(vecs[0].bytes[i], 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1 ms");
        $fatal(1);
    end

    initial begin
        int bw, br, bb;

        vecs[0] = '{"normal", 16,
                    {8'h02, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h01, 8'h20,
                     8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h11, 8'h22, 8'h33, 8'h44},
                    -1, 2, 32'h2001_0005, 32'hDEAD_BEEF, 1'b1, 1'b0};
        vecs[1] = '{"empty", 4, 128'h0, -1, 0, 32'h0, 32'h0, 1'b1, 1'b0};
        vecs[2] = '{"framing", 5, {8'h01, 8'h00, 8'h00, 8'h00, 8'hA5, 88'h0},
                    4, 0, 32'h0, 32'h0, 1'b0, 1'b1};
        vecs[3] = '{"oversize", 4, {8'h01, 8'h10, 8'h00, 8'h00, 96'h0},
                    -1, 0, 32'h0, 32'h0, 1'b0, 1'b1};
        vecs[4] = '{"max size", 8,
                    {8'h00, 8'h10, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 64'h0},
                    -1, 1, 32'h1234_5678, 32'h0, 1'b0, 1'b0};

        for (int v = 0; v < 5; v++) run_vec(vecs[v]);

        // A one-cycle low pulse in idle must produce nothing.
        do_reset();
        bw = wr_total; br = rel_total; bb = b2b_total;
        repeat (3) @(posedge clk);
        #1 rxd = 1'b0;
        @(posedge clk);
        #1 rxd = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check_result("glitch idle", bw, br, bb, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        bw = wr_total; br = rel_total; bb = b2b_total;
        send_normal(12);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_result("after glitch", bw, br, bb, 2, 32'h2001_0005, 32'hDEAD_BEEF, 1'b1, 1'b0);

        // Reset after two data bytes, then resend the whole stream.
        do_reset();
        repeat (5) @(posedge clk);
        send_normal(6);
        repeat (3) @(posedge clk);
        do_reset();
        bw = wr_total; br = rel_total; bb = b2b_total;
        repeat (5) @(posedge clk);
        send_normal(12);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_result("reset mid-word", bw, br, bb, 2, 32'h2001_0005, 32'hDEAD_BEEF, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
